// File: rtl/btb_assoc_param.sv
// Set-associative branch target buffer with 2-bit direction counters and tree pseudo-LRU.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update to the lookup outputs.
module btb_assoc_param #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned SETS      = 8,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned INDEX_LSB = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush,
  output logic              flush_busy
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_flush_set;
  logic [WAYS-1:0]   r_valid  [SETS];
  logic [WAYS-2:0]   r_plru   [SETS];
  logic [TAG_W-1:0]  r_tag    [SETS][WAYS];
  logic [ADDR_W-1:0] r_target [SETS][WAYS];
  logic [1:0]        r_ctr    [SETS][WAYS];

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit 0 = go left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] tree);
    int unsigned n;
    logic [WAY_W-1:0] way;
    logic b;
    n   = 0;
    way = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      b   = tree[n];
      way = WAY_W'({way, b});
      n   = 2 * n + (b ? 2 : 1);
    end
    return way;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WAY_W-1:0] way);
    int unsigned n;
    logic b;
    n = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      b       = way[int'(WAY_W) - 1 - l];
      tree[n] = ~b;
      n       = 2 * n + (b ? 2 : 1);
    end
    return tree;
  endfunction

  logic [IDX_W-1:0]  w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]  w_lk_tag, w_up_tag;
  logic              w_lk_hit, w_up_hit, w_has_inv;
  logic [WAY_W-1:0]  w_lk_way, w_up_hit_way, w_inv_way, w_up_way;
  logic [1:0]        w_old_ctr, w_new_ctr;
  logic [ADDR_W-1:0] w_new_target;
  logic              w_busy, w_upd_fire, w_up_write;

  assign w_lk_idx = pc_addr[INDEX_LSB +: IDX_W];
  assign w_lk_tag = pc_addr[ADDR_W-1:1];
  assign w_up_idx = upd_pc[INDEX_LSB +: IDX_W];
  assign w_up_tag = upd_pc[ADDR_W-1:1];

  // Descending scans so the lowest-numbered qualifying way wins.
  always_comb begin
    w_lk_hit     = 1'b0;
    w_lk_way     = '0;
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    w_has_inv    = 1'b0;
    w_inv_way    = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (r_valid[w_lk_idx][i] && (r_tag[w_lk_idx][i] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_way = WAY_W'(i);
      end
      if (r_valid[w_up_idx][i] && (r_tag[w_up_idx][i] == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WAY_W'(i);
      end
      if (!r_valid[w_up_idx][i]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(i);
      end
    end
  end

  assign w_busy     = (r_state == ST_FLUSH);
  assign upd_ready  = (r_state == ST_IDLE) && !flush;
  assign flush_busy = w_busy;
  assign w_upd_fire = upd_valid && upd_ready;
  assign w_up_write = w_upd_fire && (w_up_hit || upd_taken);
  assign w_up_way   = w_up_hit ? w_up_hit_way
                    : (w_has_inv ? w_inv_way : plru_victim(r_plru[w_up_idx]));
  assign w_old_ctr  = r_ctr[w_up_idx][w_up_hit_way];

  always_comb begin
    w_new_ctr    = 2'b10;
    w_new_target = upd_target;
    if (w_up_hit) begin
      if (upd_taken) begin
        w_new_ctr = (w_old_ctr == 2'b11) ? 2'b11 : w_old_ctr + 2'b01;
      end else begin
        w_new_ctr    = (w_old_ctr == 2'b00) ? 2'b00 : w_old_ctr - 2'b01;
        w_new_target = r_target[w_up_idx][w_up_hit_way];
      end
    end
  end

  always_comb begin
    pred_hit    = w_lk_hit && !w_busy;
    pred_taken  = pred_hit && r_ctr[w_lk_idx][w_lk_way][1];
    pred_target = pred_hit ? r_target[w_lk_idx][w_lk_way] : '0;
`ifdef BTB_BYPASS_EN
    if (w_up_write && (w_up_tag == w_lk_tag)) begin
      pred_hit    = 1'b1;
      pred_taken  = w_new_ctr[1];
      pred_target = w_new_target;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flush_set <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_state     <= ST_FLUSH;
            r_flush_set <= '0;
          end else if (w_up_write) begin
            r_valid[w_up_idx][w_up_way] <= 1'b1;
            r_plru[w_up_idx]            <= plru_touch(r_plru[w_up_idx], w_up_way);
          end
        end
        default: begin
          r_valid[r_flush_set] <= '0;
          r_plru[r_flush_set]  <= '0;
          if (r_flush_set == LAST_SET) begin
            r_state     <= ST_IDLE;
            r_flush_set <= '0;
          end else begin
            r_flush_set <= r_flush_set + 1'b1;
          end
        end
      endcase
    end
  end

  // Payload is left unreset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (w_up_write) begin
      r_tag[w_up_idx][w_up_way]    <= w_up_tag;
      r_target[w_up_idx][w_up_way] <= w_new_target;
      r_ctr[w_up_idx][w_up_way]    <= w_new_ctr;
    end
  end

endmodule

// File: tb/tb_btb_assoc_param.sv
// Scoreboard bench for btb_assoc_param at default parameters.
module tb_btb_assoc_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_addr;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid, upd_ready, upd_taken;
  logic [15:0] upd_pc, upd_target;
  logic        flush, flush_busy;

  typedef struct {
    logic [15:0] pc;
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  btb_assoc_param dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush),
    .flush_busy (flush_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [15:0] pc, input logic hit, input logic taken,
                          input logic [15:0] tgt);
    exp_t x;
    x.pc = pc; x.hit = hit; x.taken = taken; x.tgt = tgt;
    sb_q.push_back(x);
  endtask

  task automatic do_upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; pc_addr = 16'h0040; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
    #12;
    n_checks++;
    if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", pred_hit); end
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b want 0", pred_taken); end
    n_checks++;
    if (pred_target !== 16'h0) begin
      n_fail++; $display("FAIL reset_target got %h want 0000", pred_target);
    end
    n_checks++;
    if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", upd_ready); end
    n_checks++;
    if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", flush_busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_allocate;
    do_upd(16'h0040, 1'b1, 16'h1234);
    push_exp(16'h0040, 1'b1, 1'b1, 16'h1234);
    push_exp(16'h0050, 1'b0, 1'b0, 16'h0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL allocate pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_counter;
    // ctr starts at 2: three not-taken (2->1->0->0), four taken (1,2,3,3), two not-taken (2,1)
    logic        dir [9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic        etk [9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [15:0] etgt [9] = '{16'h1234, 16'h1234, 16'h1234, 16'h2222, 16'h2222, 16'h2222,
                              16'h2222, 16'h2222, 16'h2222};
    for (int k = 0; k < 9; k++) begin
      do_upd(16'h0040, dir[k], dir[k] ? 16'h2222 : 16'h7777);
      push_exp(16'h0040, 1'b1, etk[k], etgt[k]);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        @(negedge clk); pc_addr = e.pc; #1;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
          n_fail++;
          $display("FAIL counter step%0d got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                   k, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
        end
      end
    end
  endtask

  task automatic test_replacement;
    do_upd(16'h0840, 1'b1, 16'hA001);
    do_upd(16'h1040, 1'b1, 16'hA002);
    do_upd(16'h1840, 1'b1, 16'hA003);
    do_upd(16'h0040, 1'b1, 16'h2222);
    do_upd(16'h2040, 1'b1, 16'hA004);
    push_exp(16'h0040, 1'b1, 1'b1, 16'h2222);
    push_exp(16'h0840, 1'b1, 1'b1, 16'hA001);
    push_exp(16'h1040, 1'b0, 1'b0, 16'h0000);
    push_exp(16'h1840, 1'b1, 1'b1, 16'hA003);
    push_exp(16'h2040, 1'b1, 1'b1, 16'hA004);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL replace pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
    // Tree now points at way 1 (0x0840)
    do_upd(16'h2840, 1'b1, 16'hA005);
    push_exp(16'h0840, 1'b0, 1'b0, 16'h0000);
    push_exp(16'h2840, 1'b1, 1'b1, 16'hA005);
    push_exp(16'h0040, 1'b1, 1'b1, 16'h2222);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL replace2 pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    pc_addr = 16'h0040; flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 16'h0050; upd_taken = 1'b1; upd_target = 16'h5555;
    #1;
    n_checks++;
    if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL flush_start_ready got %b want 0", upd_ready); end
    @(posedge clk);
    #1 flush = 1'b0; upd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({flush_busy, upd_ready, pred_hit} !== 3'b100) begin
        n_fail++;
        $display("FAIL flush_cycle%0d busy/ready/hit got %b want 100", i,
                 {flush_busy, upd_ready, pred_hit});
      end
      if (i == 2) flush = 1'b1;
      if (i == 3) flush = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({flush_busy, upd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_end busy/ready got %b want 01", {flush_busy, upd_ready});
    end
    push_exp(16'h0040, 1'b0, 1'b0, 16'h0000);
    push_exp(16'h0050, 1'b0, 1'b0, 16'h0000);
    push_exp(16'h2840, 1'b0, 1'b0, 16'h0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL post_flush pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_same_cycle;
    logic        exp_hit;
    logic [15:0] exp_tgt;
`ifdef BTB_BYPASS_EN
    exp_hit = 1'b1; exp_tgt = 16'h4321;
`else
    exp_hit = 1'b0; exp_tgt = 16'h0000;
`endif
    @(negedge clk);
    pc_addr = 16'h0060;
    upd_valid = 1'b1; upd_pc = 16'h0060; upd_taken = 1'b1; upd_target = 16'h4321;
    #1;
    n_checks++;
    if ({pred_hit, pred_target} !== {exp_hit, exp_tgt}) begin
      n_fail++;
      $display("FAIL same_cycle got hit=%b tgt=%h want hit=%b tgt=%h",
               pred_hit, pred_target, exp_hit, exp_tgt);
    end
    @(posedge clk);
    #1 upd_valid = 1'b0;
    push_exp(16'h0060, 1'b1, 1'b1, 16'h4321);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL same_cycle_next pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 16'h0070; upd_taken = 1'b1; upd_target = 16'hB001;
    @(posedge clk);
    #1 upd_pc = 16'h0870; upd_target = 16'hB002;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    push_exp(16'h0070, 1'b1, 1'b1, 16'hB001);
    push_exp(16'h0870, 1'b1, 1'b1, 16'hB002);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk); pc_addr = e.pc; #1;
      n_checks++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
        n_fail++;
        $display("FAIL back_to_back pc=%h got hit=%b tk=%b tgt=%h want hit=%b tk=%b tgt=%h",
                 e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_replacement();
    test_flush();
    test_same_cycle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_assoc_param.md
Name: btb_assoc_param

Overview:
- Parametrised set-associative branch target buffer for the LC-3b fetch stage.
- Gives a same-cycle lookup on the fetch PC: hit, taken prediction and target.
- Accepts branch-resolution updates from writeback: allocate, retarget and train per-entry 2-bit direction counters.
- Uses tree pseudo-LRU replacement and supports a multi-cycle flush sweep.

Parameters:
- ADDR_W, 16, address/target width; tag = addr[ADDR_W-1:1].
- SETS, 8, number of sets; power of 2, range 2..64.
- WAYS, 4, associativity; power of 2, range 2..8.
- INDEX_LSB, 4, lowest address bit of the set index; index = addr[INDEX_LSB +: log2(SETS)].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_addr  in  ADDR_W  fetch PC to look up.
- pred_hit  out  1  valid tag match for pc_addr.
- pred_taken  out  1  pred_hit and matching entry counter >= 2.
- pred_target  out  ADDR_W  target of matching way; 0 when no hit.
- upd_valid  in  1  single-cycle update strobe.
- upd_ready  out  1  update accepted this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  ADDR_W  resolved target.
- flush  in  1  start an invalidate sweep (pulse).
- flush_busy  out  1  sweep in progress.

Behaviour:
- Storage per set, per way:
  - valid (1 bit), tag (ADDR_W-1 bits), target (ADDR_W bits), ctr (2 bits).
  - Per set: PLRU tree of WAYS-1 bits.
- Reset: asynchronous; clears all valid bits and all PLRU bits, and the FSM goes to IDLE. Tag, target and ctr are not reset.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0, upd_ready=1, flush_busy=0.
- Lookup:
  - Purely combinational, zero latency.
  - More than one matching way is illegal (updates never create duplicates); the lowest-numbered matching way wins.
  - Lookup never modifies PLRU.
- Update: performed when upd_valid && upd_ready, committed at the clock edge.
  - Hit in way w: ctr saturating +1 if upd_taken, -1 otherwise (bounds 0 and 3). target <= upd_target only if upd_taken. PLRU touched toward w.
  - Miss with upd_taken=1: victim = lowest-numbered invalid way, else the PLRU victim. Write valid=1, tag, target=upd_target, ctr=2'b10. PLRU touched toward the victim.
  - Miss with upd_taken=0: no state change.
- PLRU tree:
  - Node bit 0 = go left. The victim follows the node bits from the root.
  - A touch sets every node on the path to point away from the touched way.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when flush=1. A flush asserted in the same cycle as an update has priority; that update is dropped and upd_ready=0 that cycle.
  - FLUSH: set counter walks 0..SETS-1, clearing valid and PLRU of one set per cycle. Exit to IDLE after set SETS-1, so the sweep lasts exactly SETS cycles.
  - flush_busy=1 and upd_ready=0 during FLUSH; pred_hit and pred_taken are forced to 0.
  - flush asserted during FLUSH is ignored.
  - Reset mid-sweep aborts the sweep; all valid bits are cleared anyway.
- Lookup and update to the same set in the same cycle: lookup sees pre-update contents (no bypass) unless the optional feature is enabled.
- Index bits are a slice only; the tag covers all upper bits, so aliasing is impossible.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when an accepted update's upd_pc tag and index equal pc_addr in the same cycle, outputs reflect the post-update entry combinationally:
  - pred_hit=1 unless it is a miss with not-taken;
  - pred_taken = new ctr >= 2;
  - pred_target = new target.
- Undefined: no forwarding; the new entry is visible from the next cycle.

Test Plan:
- Reset, pc_addr=0x0040 -> pred_hit=0, pred_target=0, upd_ready=1, flush_busy=0.
- Update upd_pc=0x0040, taken, target=0x1234; next cycle pc_addr=0x0040 -> pred_hit=1, pred_taken=1, pred_target=0x1234.
- Counter training:
  - Two not-taken updates to 0x0040 -> ctr 2->1->0, pred_taken=0, pred_hit=1.
  - Four taken updates -> ctr saturates at 3.
  - One not-taken update -> pred_taken=1 still.
- Replacement (defaults):
  - Taken updates to 0x0040, 0x0840, 0x1040, 0x1840 (same set 4) fill ways 0..3.
  - Then a hit-update to 0x0040, then a new 0x2040 -> evicts the PLRU victim (way 2).
  - 0x0040 still hits; 0x1040 misses.
- Flush with an entry present:
  - flush_busy=1 for exactly 8 cycles, upd_ready=0 and pred_hit=0 throughout.
  - Afterwards the lookup misses.
  - An update asserted with flush is dropped.
- Same-cycle update and lookup of 0x0040 (new taken entry) -> pred_hit=0 without BTB_BYPASS_EN; pred_hit=1 with target=upd_target when BTB_BYPASS_EN is defined.
